dmem_arbiter: RTL and testbench

- Shares the single-port 32x32 data memory between two requesters:
  - the pipeline MEM stage (CPU port);
  - a debug/program-loader port (DBG port).
- Sits between the EX/MEM pipeline register and the data memory. It drives the memory's address, writeData, memWrite and memRead inputs, and routes readData back to the granted requester.
- Round-robin arbitration; the DBG port may lock the memory for bursts, bounded by a starvation limit.
- Raises a pipeline stall whenever the CPU request is not served in the current cycle.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_port_mux.sv | 52 +++++
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizes for the data-memory arbiter slice.
// Holds port-select and FSM state encodings plus the memory geometry.
package dmem_pkg;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam int DMEM_DEPTH = 32;
    localparam int DMEM_IDX_W = 5;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// slave: arbiter view (requests in, grants/memory controls out); master: the rest.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_gnt;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic              dbg_lock;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_gnt;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_gnt, cpu_stall,
        input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_gnt,
        output mem_addr, mem_wdata, mem_write, mem_read,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_gnt, cpu_stall,
        output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_gnt,
        input  mem_addr, mem_wdata, mem_write, mem_read,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_port_mux.sv
// Combinational request/data mux toward the memory and read-data gating back.
// Ports: sel/valid pick the port; cpu*/dbg* request side; mem* memory side.
module dmem_port_mux
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  port_e             sel,
    input  logic              valid,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWdata,
    input  logic              dbgWe,
    input  logic [ADDR_W-1:0] dbgAddr,
    input  logic [DATA_W-1:0] dbgWdata,
    input  logic [DATA_W-1:0] memRdata,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    output logic              memWrite,
    output logic              memRead,
    output logic [DATA_W-1:0] cpuRdata,
    output logic [DATA_W-1:0] dbgRdata
);

    always_comb begin
        memAddr  = '0;
        memWdata = '0;
        memWrite = 1'b0;
        memRead  = 1'b0;
        cpuRdata = '0;
        dbgRdata = '0;
        unique case (1'b1)
            (valid && sel == PORT_CPU): begin
                memAddr  = cpuAddr;
                memWdata = cpuWdata;
                memWrite = cpuWe;
                memRead  = !cpuWe;
                if (!cpuWe) cpuRdata = memRdata;
            end
            (valid && sel == PORT_DBG): begin
                memAddr  = dbgAddr;
                memWdata = dbgWdata;
                memWrite = dbgWe;
                memRead  = !dbgWe;
                if (!dbgWe) dbgRdata = memRdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data memory between MEM stage and debug port.
// Ports: CLK, RST (sync, active high), bus (dmem_arbiter_if.slave);
// err (sticky out-of-range flag) only when DMEM_ARB_RANGE_CHECK_EN is defined.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic CLK,
    input  logic RST,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_RANGE_CHECK_EN
    ,
    output logic err
`endif
);

    localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

    state_e     state;
    port_e      last;
    logic [7:0] lockCnt;

    logic  cpuGnt;
    logic  dbgGnt;
    logic  anyGnt;
    logic  accOk;
    logic  forced;
    port_e sel;

    always_comb begin
        cpuGnt = 1'b0;
        dbgGnt = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cpuGnt = bus.cpu_req &&
                         (!bus.dbg_req || last == PORT_DBG);
                dbgGnt = bus.dbg_req && !cpuGnt;
            end
            ST_LOCKED: begin
                dbgGnt = bus.dbg_req;
            end
        endcase
    end

    assign anyGnt = cpuGnt | dbgGnt;
    assign sel    = dbgGnt ? PORT_DBG : PORT_CPU;
    assign forced = (state == ST_LOCKED) && bus.cpu_req &&
                    (lockCnt == LOCK_LAST);

`ifdef DMEM_ARB_RANGE_CHECK_EN
    logic [ADDR_W-1:0] selAddr;
    logic              oor;

    assign selAddr = dbgGnt ? bus.dbg_addr : bus.cpu_addr;
    assign oor     = |selAddr[ADDR_W-1:DMEM_IDX_W];
    // Out-of-range accesses still count as granted, but never reach memory.
    assign accOk   = anyGnt && !oor;

    always_ff @(posedge CLK) begin
        if (RST) err <= 1'b0;
        else if (anyGnt && oor) err <= 1'b1;
    end
`else
    assign accOk = anyGnt;
`endif

    dmem_port_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mux (
        .sel      (sel),
        .valid    (accOk),
        .cpuWe    (bus.cpu_we),
        .cpuAddr  (bus.cpu_addr),
        .cpuWdata (bus.cpu_wdata),
        .dbgWe    (bus.dbg_we),
        .dbgAddr  (bus.dbg_addr),
        .dbgWdata (bus.dbg_wdata),
        .memRdata (bus.mem_rdata),
        .memAddr  (bus.mem_addr),
        .memWdata (bus.mem_wdata),
        .memWrite (bus.mem_write),
        .memRead  (bus.mem_read),
        .cpuRdata (bus.cpu_rdata),
        .dbgRdata (bus.dbg_rdata)
    );

    assign bus.cpu_gnt   = cpuGnt;
    assign bus.dbg_gnt   = dbgGnt;
    assign bus.cpu_stall = bus.cpu_req && !cpuGnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            last    <= PORT_DBG;
            lockCnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (dbgGnt && bus.dbg_lock) begin
                        state   <= ST_LOCKED;
                        lockCnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (forced) begin
                        state   <= ST_IDLE;
                        lockCnt <= '0;
                    end else begin
                        if (bus.cpu_req) lockCnt <= lockCnt + 8'd1;
                        if (!bus.dbg_lock) state <= ST_IDLE;
                    end
                end
            endcase
            // A forced release hands the next contention to the CPU.
            if (cpuGnt) last <= PORT_CPU;
            else if (dbgGnt || forced) last <= PORT_DBG;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 32x32 memory model.
// Covers reset, CPU access, round robin, DBG bursts, starvation and reset-in-lock.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter_if bus ();

`ifdef DMEM_ARB_RANGE_CHECK_EN
    logic err;
    dmem_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus), .err(err));
`else
    dmem_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif

    logic [31:0] mem [32] = '{default: '0};

    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[4:0]] : 'x;

    always @(posedge CLK) begin
        if (bus.mem_write) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu(input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        bus.cpu_req   = r;
        bus.cpu_we    = w;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic dbg(input logic r, input logic w, input logic l,
                       input logic [31:0] a, input logic [31:0] d);
        bus.dbg_req   = r;
        bus.dbg_we    = w;
        bus.dbg_lock  = l;
        bus.dbg_addr  = a;
        bus.dbg_wdata = d;
    endtask

    task automatic do_reset();
        cpu(0, 0, 0, 0);
        dbg(0, 0, 0, 0, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [169:0] obs;
        do_reset();
        obs = {bus.mem_addr, bus.mem_wdata, bus.mem_write,
               bus.mem_read, bus.cpu_gnt, bus.dbg_gnt,
               bus.cpu_stall, bus.cpu_rdata, bus.dbg_rdata};
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_idle: got %h want 0", obs);
        end
`ifdef DMEM_ARB_RANGE_CHECK_EN
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err: got %b want 0", err);
        end
`endif
    endtask

    task automatic test_cpu_write_read();
        cpu(1, 1, 3, 32'hDEADBEEF);
        #1;
        total++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall,
             bus.mem_write, bus.mem_read} !== 5'b10010) begin
            bad++;
            $display("FAIL cpu_wr_flags: got %b want 10010",
                     {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall,
                      bus.mem_write, bus.mem_read});
        end
        total++;
        if (bus.mem_addr !== 32'd3 || bus.mem_wdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL cpu_wr_bus: got %h/%h want 3/deadbeef",
                     bus.mem_addr, bus.mem_wdata);
        end
        tick();
        cpu(1, 0, 3, 0);
        #1;
        total++;
        if (bus.cpu_rdata !== 32'hDEADBEEF || bus.mem_read !== 1'b1 ||
            bus.dbg_rdata !== 32'h0) begin
            bad++;
            $display("FAIL cpu_rd: got %h rd=%b dbg=%h want deadbeef 1 0",
                     bus.cpu_rdata, bus.mem_read, bus.dbg_rdata);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp;
        logic [31:0] ec;
        logic [31:0] ed;
        do_reset();
        cpu(1, 0, 3, 0);
        dbg(1, 0, 0, 3, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            exp = (i % 2 == 0) ? 3'b100 : 3'b011;
            ec  = (i % 2 == 0) ? 32'hDEADBEEF : 32'h0;
            ed  = (i % 2 == 0) ? 32'h0 : 32'hDEADBEEF;
            total++;
            if ({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall} !== exp) begin
                bad++;
                $display("FAIL rr_gnt%0d: got %b want %b", i,
                         {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall}, exp);
            end
            total++;
            if (bus.cpu_rdata !== ec || bus.dbg_rdata !== ed) begin
                bad++;
                $display("FAIL rr_data%0d: got %h/%h want %h/%h", i,
                         bus.cpu_rdata, bus.dbg_rdata, ec, ed);
            end
            tick();
        end
    endtask

    task automatic test_dbg_burst();
        cpu(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            dbg(1, 1, (i < 3), i, 32'h100 + i);
            #1;
            total++;
            if ({bus.cpu_gnt, bus.dbg_gnt, bus.mem_write} !== 3'b011 ||
                bus.mem_addr !== 32'(i)) begin
                bad++;
                $display("FAIL burst%0d: got %b a=%h want 011 a=%0d", i,
                         {bus.cpu_gnt, bus.dbg_gnt, bus.mem_write},
                         bus.mem_addr, i);
            end
            tick();
        end
        dbg(0, 0, 0, 0, 0);
        cpu(1, 0, 2, 0);
        #1;
        total++;
        if (bus.cpu_gnt !== 1'b1 || bus.cpu_rdata !== 32'h102) begin
            bad++;
            $display("FAIL burst_release: got g=%b d=%h want 1 102",
                     bus.cpu_gnt, bus.cpu_rdata);
        end
        tick();
    endtask

    task automatic test_starvation();
        do_reset();
        dbg(1, 1, 1, 10, 32'hCAFE0010);
        #1;
        total++;
        if (bus.dbg_gnt !== 1'b1) begin
            bad++;
            $display("FAIL starve_lock: got %b want 1", bus.dbg_gnt);
        end
        tick();
        cpu(1, 0, 10, 0);
        for (int i = 0; i < 8; i++) begin
            dbg((i != 3), 0, 1, 1, 0);
            #1;
            total++;
            if ({bus.cpu_gnt, bus.cpu_stall, bus.dbg_gnt} !==
                {2'b01, (i != 3)}) begin
                bad++;
                $display("FAIL starve_cyc%0d: got %b want 01%b", i + 1,
                         {bus.cpu_gnt, bus.cpu_stall, bus.dbg_gnt},
                         (i != 3));
            end
            tick();
        end
        #1;
        total++;
        if ({bus.cpu_gnt, bus.cpu_stall, bus.dbg_gnt} !== 3'b100 ||
            bus.cpu_rdata !== 32'hCAFE0010) begin
            bad++;
            $display("FAIL starve_cyc9: got %b d=%h want 100 cafe0010",
                     {bus.cpu_gnt, bus.cpu_stall, bus.dbg_gnt},
                     bus.cpu_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        dbg(1, 0, 1, 1, 0);
        tick();
        cpu(1, 0, 3, 0);
        for (int i = 0; i < 4; i++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        total++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall} !== 3'b100) begin
            bad++;
            $display("FAIL rst_lock_cpu: got %b want 100",
                     {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall});
        end
        tick();
        dbg(1, 0, 0, 1, 0);
        #1;
        total++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall} !== 3'b011) begin
            bad++;
            $display("FAIL rst_lock_dbg: got %b want 011",
                     {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall});
        end
        tick();
        cpu(0, 0, 0, 0);
        dbg(0, 0, 0, 0, 0);
    endtask

`ifdef DMEM_ARB_RANGE_CHECK_EN
    task automatic test_range();
        do_reset();
        cpu(1, 1, 32'h40, 32'h12345678);
        #1;
        total++;
        if ({bus.cpu_gnt, bus.cpu_stall, bus.mem_write,
             bus.mem_read, err} !== 5'b10000) begin
            bad++;
            $display("FAIL range_wr: got %b want 10000",
                     {bus.cpu_gnt, bus.cpu_stall, bus.mem_write,
                      bus.mem_read, err});
        end
        tick();
        cpu(1, 0, 3, 0);
        #1;
        total++;
        if (err !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF ||
            mem[0] !== 32'h100) begin
            bad++;
            $display("FAIL range_err: got e=%b d=%h m0=%h want 1 deadbeef 100",
                     err, bus.cpu_rdata, mem[0]);
        end
        tick();
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL range_sticky: got %b want 1", err);
        end
    endtask
`endif

    initial begin
        cpu(0, 0, 0, 0);
        dbg(0, 0, 0, 0, 0);
        test_reset();
        test_cpu_write_read();
        test_round_robin();
        test_dbg_burst();
        test_starvation();
        test_reset_mid_lock();
`ifdef DMEM_ARB_RANGE_CHECK_EN
        test_range();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
